yd_wb_queue: RTL and testbench



---
 rtl/yd_wb_queue.sv | 165 ++++++++++++++++
 tb/tb_yd_wb_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/yd_wb_queue.sv
// rtl/yd_wb_queue.sv - in-order write-back queue driving the register file's two write ports.
// Defining YD_WBQ_FWD_EN adds chk_data0/chk_data1 forwarding outputs.
module yd_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [3:0]                   a_addr,
  input  logic [15:0]                  a_data,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [3:0]                   b_addr,
  input  logic [15:0]                  b_data,
  output logic [3:0]                   waddr0,
  output logic [15:0]                  din0,
  output logic                         we0,
  output logic [3:0]                   waddr1,
  output logic [15:0]                  din1,
  output logic                         we1,
  output logic                         pc_wr,
  input  logic [3:0]                   chk_addr0,
  output logic                         chk_busy0,
  input  logic [3:0]                   chk_addr1,
  output logic                         chk_busy1,
`ifdef YD_WBQ_FWD_EN
  output logic [15:0]                  chk_data0,
  output logic [15:0]                  chk_data1,
`endif
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [3:0] ADDR_ZE = 4'd0;
  localparam logic [3:0] ADDR_PC = 4'd15;

  logic [3:0]    addr_q [DEPTH];
  logic [15:0]   data_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [CW-1:0] free_w;
  logic          a_push, b_push;
  logic [PW-1:0] b_idx;
  logic [CW-1:0] n_pop;
  logic          h_pc, single;

  // Entries re-indexed by age: slot 0 is the head.
  logic [3:0]    ord_addr [DEPTH];
  logic [15:0]   ord_data [DEPTH];

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ord_addr[k] = addr_q[rd_ptr_q + PW'(k)];
      ord_data[k] = data_q[rd_ptr_q + PW'(k)];
    end
  end

  // Ready looks only at the registered count, never at this cycle's pops.
  assign free_w  = DEPTH_C - count_q;
  assign a_ready = (free_w >= CW'(1));
  assign b_ready = (free_w >= CW'(2)) | ((free_w >= CW'(1)) & ~a_valid);

  assign a_push = a_valid & a_ready & (a_addr != ADDR_ZE);
  assign b_push = b_valid & b_ready & (b_addr != ADDR_ZE);
  assign b_idx  = wr_ptr_q + PW'(a_push);

  assign h_pc   = (ord_addr[0] == ADDR_PC);
  assign single = (count_q == CW'(1)) | (ord_addr[1] == ADDR_PC);

  always_comb begin
    waddr0 = '0;
    din0   = '0;
    we0    = 1'b0;
    waddr1 = '0;
    din1   = '0;
    we1    = 1'b0;
    pc_wr  = 1'b0;
    n_pop  = '0;
    if (count_q != '0) begin
      we0 = 1'b1;
      if (h_pc || single) begin
        waddr0 = ord_addr[0];
        din0   = ord_data[0];
        pc_wr  = h_pc;
        n_pop  = CW'(1);
      end else if (ord_addr[0] == ord_addr[1]) begin
        // Younger value wins; the older write is dropped entirely.
        waddr0 = ord_addr[1];
        din0   = ord_data[1];
        n_pop  = CW'(2);
      end else begin
        waddr0 = ord_addr[0];
        din0   = ord_data[0];
        waddr1 = ord_addr[1];
        din1   = ord_data[1];
        we1    = 1'b1;
        n_pop  = CW'(2);
      end
    end
  end

  always_comb begin
    chk_busy0 = 1'b0;
    chk_busy1 = 1'b0;
`ifdef YD_WBQ_FWD_EN
    chk_data0 = '0;
    chk_data1 = '0;
`endif
    // Ascending age scan, so the last match is the youngest entry.
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_q) && (CW'(k) >= n_pop)) begin
        if ((chk_addr0 != ADDR_ZE) && (ord_addr[k] == chk_addr0)) begin
          chk_busy0 = 1'b1;
`ifdef YD_WBQ_FWD_EN
          chk_data0 = ord_data[k];
`endif
        end
        if ((chk_addr1 != ADDR_ZE) && (ord_addr[k] == chk_addr1)) begin
          chk_busy1 = 1'b1;
`ifdef YD_WBQ_FWD_EN
          chk_data1 = ord_data[k];
`endif
        end
      end
    end
  end

  assign rd_ptr_d = rd_ptr_q + PW'(n_pop);
  assign wr_ptr_d = wr_ptr_q + PW'(a_push) + PW'(b_push);
  assign count_d  = count_q + CW'(a_push) + CW'(b_push) - n_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      if (a_push) begin
        addr_q[wr_ptr_q] <= a_addr;
        data_q[wr_ptr_q] <= a_data;
      end
      if (b_push) begin
        addr_q[b_idx] <= b_addr;
        data_q[b_idx] <= b_data;
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: tb/tb_yd_wb_queue.sv
// tb/tb_yd_wb_queue.sv - self-checking bench for yd_wb_queue (DEPTH=4).
module tb_yd_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic [3:0]  waddr0, waddr1;
  logic [15:0] din0, din1;
  logic        we0, we1, pc_wr;
  logic [3:0]  chk_addr0, chk_addr1;
  logic        chk_busy0, chk_busy1;
`ifdef YD_WBQ_FWD_EN
  logic [15:0] chk_data0, chk_data1;
`endif
  logic        empty;
  logic [2:0]  count;

  always #5 clk = ~clk;

  yd_wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .waddr0(waddr0), .din0(din0), .we0(we0),
    .waddr1(waddr1), .din1(din1), .we1(we1), .pc_wr(pc_wr),
    .chk_addr0(chk_addr0), .chk_busy0(chk_busy0),
    .chk_addr1(chk_addr1), .chk_busy1(chk_busy1),
`ifdef YD_WBQ_FWD_EN
    .chk_data0(chk_data0), .chk_data1(chk_data1),
`endif
    .empty(empty), .count(count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                       input logic bv, input logic [3:0] ba, input logic [15:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  typedef struct {
    logic        av; logic [3:0] aa; logic [15:0] ad;
    logic        bv; logic [3:0] ba; logic [15:0] bd;
    logic        we0; logic [3:0] wa0; logic [15:0] wd0;
    logic        we1; logic [3:0] wa1; logic [15:0] wd1;
    logic        pc;  int cnt;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  typedef struct { logic [3:0] addr; logic [15:0] data; } ent_t;
  ent_t mq[$];

  function automatic logic [3:0] rnd_addr();
    case ($urandom_range(0, 7))
      0:       return 4'd0;
      1:       return 4'd15;
      default: return 4'($urandom_range(1, 5));
    endcase
  endfunction

  // Reference model: evaluate the spec's retire rules on a plain queue.
  logic        e_ar, e_br, e_we0, e_we1, e_pc, e_b0, e_b1;
  logic [3:0]  e_wa0, e_wa1;
  logic [15:0] e_wd0, e_wd1, e_d0, e_d1;
  int          e_np;

  task automatic model_eval();
    int cnt;
    cnt  = mq.size();
    e_ar = (4 - cnt) >= 1;
    e_br = ((4 - cnt) >= 2) || (((4 - cnt) >= 1) && !a_valid);
    e_we0 = 0; e_wa0 = 0; e_wd0 = 0; e_we1 = 0; e_wa1 = 0; e_wd1 = 0; e_pc = 0; e_np = 0;
    if (cnt > 0) begin
      e_we0 = 1;
      if (mq[0].addr == 15) begin
        e_wa0 = mq[0].addr; e_wd0 = mq[0].data; e_pc = 1; e_np = 1;
      end else if (cnt == 1 || mq[1].addr == 15) begin
        e_wa0 = mq[0].addr; e_wd0 = mq[0].data; e_np = 1;
      end else if (mq[0].addr == mq[1].addr) begin
        e_wa0 = mq[1].addr; e_wd0 = mq[1].data; e_np = 2;
      end else begin
        e_wa0 = mq[0].addr; e_wd0 = mq[0].data;
        e_we1 = 1; e_wa1 = mq[1].addr; e_wd1 = mq[1].data; e_np = 2;
      end
    end
    e_b0 = 0; e_b1 = 0; e_d0 = 0; e_d1 = 0;
    for (int k = e_np; k < cnt; k++) begin
      if (chk_addr0 != 0 && mq[k].addr == chk_addr0) begin e_b0 = 1; e_d0 = mq[k].data; end
      if (chk_addr1 != 0 && mq[k].addr == chk_addr1) begin e_b1 = 1; e_d1 = mq[k].data; end
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < e_np; k++) void'(mq.pop_front());
    if (a_valid && e_ar && a_addr != 0) mq.push_back('{a_addr, a_data});
    if (b_valid && e_br && b_addr != 0) mq.push_back('{b_addr, b_data});
  endtask

  initial begin
    vecs[0]  = '{1, 4'd3,  16'h1111, 1, 4'd4,  16'h2222, 1, 4'd3,  16'h1111, 1, 4'd4,  16'h2222, 0, 2};
    vecs[1]  = '{0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 0};
    vecs[2]  = '{1, 4'd5,  16'hAAAA, 1, 4'd5,  16'hBBBB, 1, 4'd5,  16'hBBBB, 0, 4'd0,  16'h0000, 0, 2};
    vecs[3]  = '{1, 4'd15, 16'h0040, 1, 4'd6,  16'h0007, 1, 4'd15, 16'h0040, 0, 4'd0,  16'h0000, 1, 2};
    vecs[4]  = '{0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 4'd6,  16'h0007, 0, 4'd0,  16'h0000, 0, 1};
    vecs[5]  = '{0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 0};
    vecs[6]  = '{1, 4'd0,  16'h1234, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 0};
    vecs[7]  = '{1, 4'd2,  16'h5A5A, 1, 4'd0,  16'h4321, 1, 4'd2,  16'h5A5A, 0, 4'd0,  16'h0000, 0, 1};
    vecs[8]  = '{1, 4'd1,  16'h0D0D, 1, 4'd14, 16'hEEEE, 1, 4'd1,  16'h0D0D, 1, 4'd14, 16'hEEEE, 0, 2};
    vecs[9]  = '{0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 0};
    vecs[10] = '{1, 4'd9,  16'h9999, 1, 4'd15, 16'hF0F0, 1, 4'd9,  16'h9999, 0, 4'd0,  16'h0000, 0, 2};
    vecs[11] = '{0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 1, 4'd15, 16'hF0F0, 0, 4'd0,  16'h0000, 1, 1};
    vecs[12] = '{0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 0, 0};

    // Reset held for two cycles with A presenting a value.
    rst_n = 1'b0; chk_addr0 = 0; chk_addr1 = 0;
    drive(1, 4'd3, 16'hC0DE, 0, 4'd0, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_we0", 32'(we0), 0);
    chk("rst_we1", 32'(we1), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_pc_wr", 32'(pc_wr), 0);
    chk("rst_waddr0", 32'(waddr0), 0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    drive(0, 4'd0, 16'h0, 0, 4'd0, 16'h0); #1;
    chk("post_rst_we0", 32'(we0), 1);
    chk("post_rst_waddr0", 32'(waddr0), 3);
    chk("post_rst_din0", 32'(din0), 32'hC0DE);
    chk("post_rst_count", 32'(count), 1);
    @(posedge clk); @(negedge clk); #1;
    chk("post_rst_empty", 32'(empty), 1);

    // Table-driven single-cycle vectors.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
      @(posedge clk); @(negedge clk);
      drive(0, 4'd0, 16'h0, 0, 4'd0, 16'h0); #1;
      chk($sformatf("v%0d_we0", i), 32'(we0), 32'(vecs[i].we0));
      chk($sformatf("v%0d_we1", i), 32'(we1), 32'(vecs[i].we1));
      chk($sformatf("v%0d_pc_wr", i), 32'(pc_wr), 32'(vecs[i].pc));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      if (vecs[i].we0 || vecs[i].cnt == 0) begin
        chk($sformatf("v%0d_waddr0", i), 32'(waddr0), 32'(vecs[i].wa0));
        chk($sformatf("v%0d_din0", i), 32'(din0), 32'(vecs[i].wd0));
      end
      if (vecs[i].we1 || vecs[i].cnt == 0) begin
        chk($sformatf("v%0d_waddr1", i), 32'(waddr1), 32'(vecs[i].wa1));
        chk($sformatf("v%0d_din1", i), 32'(din1), 32'(vecs[i].wd1));
      end
    end

    // Scoreboard: queue holds 7,8,9 with 7 and 8 retiring together.
    drive(1, 4'd15, 16'h0100, 1, 4'd7, 16'h0777);
    @(posedge clk); @(negedge clk);
    drive(1, 4'd8, 16'h0888, 1, 4'd9, 16'h0999);
    @(posedge clk); @(negedge clk);
    drive(0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    chk_addr0 = 4'd9; chk_addr1 = 4'd7; #1;
    chk("sb_count3", 32'(count), 3);
    chk("sb_busy0_9", 32'(chk_busy0), 1);
    chk("sb_busy1_7_popping", 32'(chk_busy1), 0);
    chk("sb_retire_waddr0", 32'(waddr0), 7);
    chk("sb_retire_waddr1", 32'(waddr1), 8);
    chk_addr1 = 4'd8; #1;
    chk("sb_busy1_8_popping", 32'(chk_busy1), 0);
    chk_addr0 = 4'd0; #1;
    chk("sb_busy0_ze", 32'(chk_busy0), 0);
    @(posedge clk); @(negedge clk);
    chk_addr0 = 4'd9; #1;
    chk("sb_busy0_9_last_pop", 32'(chk_busy0), 0);
    chk_addr0 = 0; chk_addr1 = 0;
    @(posedge clk); @(negedge clk); #1;
    chk("sb_drained", 32'(empty), 1);

    // Backpressure with PC entries forcing one retire per cycle.
    drive(1, 4'd15, 16'h0001, 1, 4'd15, 16'h0002);
    @(posedge clk); @(negedge clk);
    drive(1, 4'd15, 16'h0003, 1, 4'd15, 16'h0004); #1;
    chk("bp_cnt2_a_ready", 32'(a_ready), 1);
    chk("bp_cnt2_b_ready", 32'(b_ready), 1);
    @(posedge clk); @(negedge clk);
    drive(1, 4'd15, 16'h0005, 1, 4'd15, 16'h0006); #1;
    chk("bp_count3", 32'(count), 3);
    chk("bp_cnt3_a_ready", 32'(a_ready), 1);
    chk("bp_cnt3_b_ready_a_valid", 32'(b_ready), 0);
    chk("bp_pc_wr", 32'(pc_wr), 1);
    chk("bp_we1", 32'(we1), 0);
    @(posedge clk); @(negedge clk);
    drive(0, 4'd0, 16'h0, 1, 4'd15, 16'h0006); #1;
    chk("bp_cnt3_b_ready_no_a", 32'(b_ready), 1);
    @(posedge clk); @(negedge clk);
    drive(0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    for (int k = 4; k <= 6; k++) begin
      #1;
      chk($sformatf("bp_drain%0d_din0", k), 32'(din0), 32'(k));
      chk($sformatf("bp_drain%0d_pc_wr", k), 32'(pc_wr), 1);
      @(posedge clk); @(negedge clk);
    end
    #1;
    chk("bp_empty", 32'(empty), 1);

    // Randomized traffic against the queue model.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 2) != 0, rnd_addr(), 16'($urandom()),
            $urandom_range(0, 2) != 0, rnd_addr(), 16'($urandom()));
      chk_addr0 = rnd_addr();
      chk_addr1 = rnd_addr();
      #1;
      model_eval();
      chk($sformatf("rnd%0d_a_ready", c), 32'(a_ready), 32'(e_ar));
      chk($sformatf("rnd%0d_b_ready", c), 32'(b_ready), 32'(e_br));
      chk($sformatf("rnd%0d_count", c), 32'(count), 32'(mq.size()));
      chk($sformatf("rnd%0d_empty", c), 32'(empty), 32'(mq.size() == 0));
      chk($sformatf("rnd%0d_we0", c), 32'(we0), 32'(e_we0));
      chk($sformatf("rnd%0d_waddr0", c), 32'(waddr0), 32'(e_wa0));
      chk($sformatf("rnd%0d_din0", c), 32'(din0), 32'(e_wd0));
      chk($sformatf("rnd%0d_we1", c), 32'(we1), 32'(e_we1));
      if (e_we1) begin
        chk($sformatf("rnd%0d_waddr1", c), 32'(waddr1), 32'(e_wa1));
        chk($sformatf("rnd%0d_din1", c), 32'(din1), 32'(e_wd1));
      end
      chk($sformatf("rnd%0d_pc_wr", c), 32'(pc_wr), 32'(e_pc));
      chk($sformatf("rnd%0d_busy0", c), 32'(chk_busy0), 32'(e_b0));
      chk($sformatf("rnd%0d_busy1", c), 32'(chk_busy1), 32'(e_b1));
`ifdef YD_WBQ_FWD_EN
      chk($sformatf("rnd%0d_data0", c), 32'(chk_data0), 32'(e_d0));
      chk($sformatf("rnd%0d_data1", c), 32'(chk_data1), 32'(e_d1));
`endif
      @(posedge clk);
      model_update();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
